// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 types, FSM encoding and byte-permutation
//                helpers for the iterative round datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ROUND = 1'b1
    } fsm_state_e;

    // GF(2^8) multiply-by-two, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i = row (i%4), column (i/4); byte 0 lives in [127:120]
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mixcolumn.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mixcolumn
//  Description : One 32-bit state column through MixColumns (i_dec=0) or
//                InvMixColumns (i_dec=1). Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_dec,
    output logic [31:0] o_col
);

    // Byte multiples shared by both matrices: a, 2a, 4a, 8a
    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        localparam int c_I1 = (i + 1) % 4;
        localparam int c_I2 = (i + 2) % 4;
        localparam int c_I3 = (i + 3) % 4;

        logic [7:0] w_enc;
        logic [7:0] w_dec;

        assign w_a[i]  = i_col[31 - 8*i -: 8];
        assign w_x2[i] = xtime(w_a[i]);
        assign w_x4[i] = xtime(w_x2[i]);
        assign w_x8[i] = xtime(w_x4[i]);

        // {02,03,01,01} row, rotated per output byte
        assign w_enc = w_x2[i] ^ (w_x2[c_I1] ^ w_a[c_I1]) ^ w_a[c_I2] ^ w_a[c_I3];

        // {0e,0b,0d,09} row: 0e=8+4+2, 0b=8+2+1, 0d=8+4+1, 09=8+1
        assign w_dec = (w_x8[i]    ^ w_x4[i]    ^ w_x2[i])
                     ^ (w_x8[c_I1] ^ w_x2[c_I1] ^ w_a[c_I1])
                     ^ (w_x8[c_I2] ^ w_x4[c_I2] ^ w_a[c_I2])
                     ^ (w_x8[c_I3] ^ w_a[c_I3]);

        assign o_col[31 - 8*i -: 8] = i_dec ? w_dec : w_enc;
    end

endmodule
`default_nettype wire

// File: rtl/aes_round_state.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_state
//  Description : Iterative AES-128 round controller. Holds the cipher state,
//                drives an external 16-byte S-box layer and applies
//                AddRoundKey, (Inv)ShiftRows and (Inv)MixColumns around it,
//                one round per clock. Round keys come from an external store.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_state #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         dec_i,
    input  logic [127:0] data_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic [127:0] sb_in_o,
    input  logic [127:0] sb_out_i,
    output logic         sb_dec_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] data_o
);
    import aes_pkg::*;

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

    fsm_state_e r_fsm;
    aes_state_t r_state;
    logic [3:0] r_round;
    logic       r_dec;
    logic       r_busy;
    logic       r_done;
    aes_state_t r_data;

    aes_state_t w_sr;
    aes_state_t w_dec_v;
    aes_state_t w_mix_in;
    aes_state_t w_mix_out;

    // Encrypt: ShiftRows after the S-box; decrypt: InvShiftRows before it,
    // so the S-box layer always sits directly on the state register path
    assign sb_in_o  = (r_fsm == S_ROUND && r_dec) ? inv_shift_rows(r_state) : r_state;
    assign sb_dec_o = r_dec;

    assign w_sr     = shift_rows(sb_out_i);
    assign w_dec_v  = sb_out_i ^ rk_i;
    assign w_mix_in = r_dec ? w_dec_v : w_sr;

    for (genvar i = 0; i < 4; i++) begin : g_col
        aes_mixcolumn u_mixcol (
            .i_col (w_mix_in[127 - 32*i -: 32]),
            .i_dec (r_dec),
            .o_col (w_mix_out[127 - 32*i -: 32])
        );
    end

    // Key index: the running round counter, or the first key to be used
    // by an operation about to start
    always_comb begin
        rk_idx_o = 4'd0;
        if (r_fsm == S_ROUND) begin
            rk_idx_o = r_round;
        end else if (dec_i) begin
            rk_idx_o = c_LAST_ROUND;
        end
    end

    // Round controller: initial key add on start, one round per cycle after
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= 4'd0;
            r_dec   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start_i) begin
                        r_dec   <= dec_i;
                        r_state <= data_i ^ rk_i;
                        r_round <= dec_i ? (c_LAST_ROUND - 4'd1) : 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (!r_dec) begin
                        if (r_round == c_LAST_ROUND) begin
                            r_data <= w_sr ^ rk_i;
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                            r_fsm  <= S_IDLE;
                        end else begin
                            r_state <= w_mix_out ^ rk_i;
                            r_round <= r_round + 4'd1;
                        end
                    end else begin
                        if (r_round == 4'd0) begin
                            r_data <= w_dec_v;
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                            r_fsm  <= S_IDLE;
                        end else begin
                            r_state <= w_mix_out;
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_state.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_state
//  Description : Self-checking bench for aes_round_state. Provides the S-box
//                layer and key store behaviourally, and checks results
//                against a textbook AES-128 model through a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_state;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         dec_i;
    logic [127:0] data_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic [127:0] sb_in_o;
    logic [127:0] sb_out_i;
    logic         sb_dec_o;
    logic         busy_o;
    logic         done_o;
    logic [127:0] data_o;

    logic [10:0][127:0] rk_tab;
    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] data;
        logic         dec;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rk_seq[$];

    always #5 clk = ~clk;

    // Cycle counter used for latency bookkeeping
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_state #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .dec_i    (dec_i),
        .data_i   (data_i),
        .rk_idx_o (rk_idx_o),
        .rk_i     (rk_i),
        .sb_in_o  (sb_in_o),
        .sb_out_i (sb_out_i),
        .sb_dec_o (sb_dec_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .data_o   (data_o)
    );

    // ---------------- GF(2^8) and S-box from first principles -------------
    function automatic logic [7:0] gf_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = gf_xt(a);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sb_layer(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv ? inv_sbox(v[127 - 8*i -: 8]) : sbox(v[127 - 8*i -: 8]);
        return o;
    endfunction

    // External S-box layer and key store
    always_comb sb_out_i = sb_layer(sb_in_o, sb_dec_o);
    assign rk_i = (rk_idx_o <= 4'd10) ? rk_tab[int'(rk_idx_o)] : 128'h0;

    // ---------------- Textbook AES-128 reference ---------------------------
    function automatic logic [10:0][127:0] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [10:0][127:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = gf_xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Row r (bytes r, r+4, r+8, r+12) rotated left by r (or right, inverse)
    function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [31:0]  row;
        logic [63:0]  dbl;
        int           amt;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[31 - 8*c -: 8] = s[127 - 8*(r + 4*c) -: 8];
            dbl = {row, row};
            amt = inv ? (4 - r) % 4 : r;
            row = dbl[63 - 8*amt -: 32];
            for (int c = 0; c < 4; c++) o[127 - 8*(r + 4*c) -: 8] = row[31 - 8*c -: 8];
        end
        return o;
    endfunction

    // Circulant matrix product per column
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] o;
        o = '0;
        if (inv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
        else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - r + 4) % 4], a[k]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_cipher(input logic [127:0] key, input logic [127:0] blk,
                                                input bit decrypt);
        logic [10:0][127:0] ks;
        logic [127:0] s;
        ks = expand(key);
        s  = blk;
        if (!decrypt) begin
            s = s ^ ks[0];
            for (int rnd = 1; rnd <= 10; rnd++) begin
                s = ref_shift(sb_layer(s, 1'b0), 1'b0);
                if (rnd < 10) s = ref_mix(s, 1'b0);
                s = s ^ ks[rnd];
            end
        end else begin
            s = s ^ ks[10];
            for (int rnd = 9; rnd >= 0; rnd--) begin
                s = sb_layer(ref_shift(s, 1'b1), 1'b1);
                s = s ^ ks[rnd];
                if (rnd > 0) s = ref_mix(s, 1'b1);
            end
        end
        return s;
    endfunction

    // ---------------- Checking helpers -------------------------------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every completion is matched to the oldest outstanding request
    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] act_seq;
        logic [127:0] exp_seq;
        if (!rst_n) begin
            rk_seq.delete();
        end else begin
            if (busy_o) rk_seq.push_back(int'(rk_idx_o));
            if (done_o) begin
                check("done_expected", (exp_q.size() == 0) ? 128'd1 : 128'd0, 128'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data_o", data_o, e.data);
                    check("sb_dec_o", sb_dec_o, e.dec);
                    check("done_latency", cyc, e.done_cyc);
                    check("busy_at_done", busy_o, 1'b0);
                    act_seq = '0;
                    foreach (rk_seq[i]) act_seq = (act_seq << 4) | 128'(rk_seq[i] & 15);
                    act_seq = (act_seq << 8) | 128'(rk_seq.size());
                    exp_seq = '0;
                    for (int i = 0; i < 10; i++)
                        exp_seq = (exp_seq << 4) | 128'(e.dec ? 9 - i : i + 1);
                    exp_seq = (exp_seq << 8) | 128'd10;
                    check("rk_idx_seq", act_seq, exp_seq);
                end
                rk_seq.delete();
            end
        end
    end

    // ---------------- Stimulus ---------------------------------------------
    // Called one step after a rising edge with the DUT idle; returns one
    // step after the edge that samples the start
    task automatic start_op(input logic d, input logic [127:0] x, input logic [127:0] expv);
        start_i = 1'b1;
        dec_i   = d;
        data_i  = x;
        exp_q.push_back('{expv, d, cyc + 11});
        #1;
        check("rk_idx_idle", rk_idx_o, d ? 4'd10 : 4'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    task automatic wait_done_pulse();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", done_o, 1'b1);
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic         d;
        int           n;

        rst_n   = 1'b0;
        start_i = 1'b0;
        dec_i   = 1'b0;
        data_i  = '0;
        rk_tab  = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_data", data_o, 128'h0);
        check("rst_sb_dec", sb_dec_o, 1'b0);
        check("rst_sb_in", sb_in_o, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 Appendix B
        start_op(1'b0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
        wait_idle();

        // FIPS-197 Appendix C.1 encrypt and decrypt
        rk_tab = expand(128'h000102030405060708090a0b0c0d0e0f);
        start_op(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        wait_idle();
        start_op(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
        wait_idle();
        check("sb_dec_hold_idle", sb_dec_o, 1'b1);

        // Random keys and blocks, both directions
        for (int t = 0; t < 4; t++) begin
            key = rand128();
            pt  = rand128();
            ct  = rand128();
            rk_tab = expand(key);
            start_op(1'b0, pt, ref_cipher(key, pt, 1'b0));
            wait_idle();
            start_op(1'b1, ct, ref_cipher(key, ct, 1'b1));
            wait_idle();
        end

        // Back-to-back: enc then dec, each started in the previous done cycle
        key = rand128();
        pt  = rand128();
        rk_tab = expand(key);
        ct  = ref_cipher(key, pt, 1'b0);
        start_op(1'b0, pt, ct);
        wait_done_pulse();
        start_op(1'b1, ct, pt);
        wait_done_pulse();
        pt = rand128();
        start_op(1'b0, pt, ref_cipher(key, pt, 1'b0));
        wait_idle();

        // Reset during round 5 aborts without a completion
        pt = rand128();
        start_op(1'b0, pt, ref_cipher(key, pt, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_data", data_o, 128'h0);
        check("abort_sb_dec", sb_dec_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        ct = rand128();
        start_op(1'b1, ct, ref_cipher(key, ct, 1'b1));
        wait_idle();

        // Start held high with inputs churning mid-run
        pt = rand128();
        start_i = 1'b1;
        dec_i   = 1'b0;
        data_i  = pt;
        exp_q.push_back('{ref_cipher(key, pt, 1'b0), 1'b0, cyc + 11});
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (done_o !== 1'b1) begin
                data_i = rand128();
                dec_i  = 1'($urandom_range(1));
            end
        end while (done_o !== 1'b1 && n < 40);
        check("held_done_seen", done_o, 1'b1);
        d       = 1'($urandom_range(1));
        data_i  = rand128();
        dec_i   = d;
        exp_q.push_back('{ref_cipher(key, data_i, d), d, cyc + 11});
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
